split_arbiter: RTL and testbench

SPLIT_ARBITER -- requirements
Module: split_arbiter

---
 rtl/split_arbiter.sv | 174 +++++++++++++++++
 tb/tb_split_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : split_arbiter
// Brief    : Two-master round-robin bus arbiter with one outstanding split.
// Revision : 1.0
// ============================================================================
module split_arbiter #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       m1_breq,
    input  logic       m2_breq,
    input  logic       ssplit,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       m1_split,
    output logic       m2_split,
    output logic       split_grant,
    output logic [1:0] bus_owner
);

    localparam logic [1:0] C_IDLE      = 2'd0;
    localparam logic [1:0] C_GRANT1    = 2'd1;
    localparam logic [1:0] C_GRANT2    = 2'd2;
    localparam logic [1:0] C_SPLIT_RET = 2'd3;

    localparam logic [1:0] C_OWN_NONE  = 2'b00;
    localparam logic [1:0] C_OWN_M1    = 2'b01;
    localparam logic [1:0] C_OWN_M2    = 2'b10;

    logic [1:0] state_q, state_d;
    logic       ssplit_dly_q, ssplit_dly_d;
    logic       split_pending_q, split_pending_d;
    logic       split_master_q, split_master_d;
    logic       last_grant_q, last_grant_d;
    logic       m1_grant_q, m1_grant_d;
    logic       m2_grant_q, m2_grant_d;
    logic       m1_split_q, m1_split_d;
    logic       m2_split_q, m2_split_d;
    logic       split_grant_q, split_grant_d;
    logic [1:0] bus_owner_q, bus_owner_d;

    logic       w_m1_elig;
    logic       w_m2_elig;
    logic       w_split_rise;
    logic       w_owner_breq;
    logic       w_split_master_breq;

    // A parked master may not re-arbitrate until its split has been returned.
    assign w_m1_elig = m1_breq && !(split_pending_q && !split_master_q);
    assign w_m2_elig = m2_breq && !(split_pending_q &&  split_master_q);

    assign w_split_rise        = SPLIT_EN && ssplit && !ssplit_dly_q && !split_pending_q;
    assign w_owner_breq        = (state_q == C_GRANT2) ? m2_breq : m1_breq;
    assign w_split_master_breq = split_master_q ? m2_breq : m1_breq;

    always_comb begin
        state_d         = state_q;
        ssplit_dly_d    = ssplit;
        split_pending_d = split_pending_q;
        split_master_d  = split_master_q;
        last_grant_d    = last_grant_q;
        m1_grant_d      = m1_grant_q;
        m2_grant_d      = m2_grant_q;
        m1_split_d      = m1_split_q;
        m2_split_d      = m2_split_q;
        split_grant_d   = split_grant_q;
        bus_owner_d     = bus_owner_q;

        case (state_q)
            C_IDLE: begin
                if (split_pending_q && !ssplit) begin
                    state_d       = C_SPLIT_RET;
                    split_grant_d = 1'b1;
                    last_grant_d  = split_master_q;
                    if (split_master_q) begin
                        m2_grant_d  = 1'b1;
                        m2_split_d  = 1'b0;
                        bus_owner_d = C_OWN_M2;
                    end else begin
                        m1_grant_d  = 1'b1;
                        m1_split_d  = 1'b0;
                        bus_owner_d = C_OWN_M1;
                    end
                end else if (w_m1_elig && (!w_m2_elig || last_grant_q)) begin
                    state_d      = C_GRANT1;
                    m1_grant_d   = 1'b1;
                    bus_owner_d  = C_OWN_M1;
                    last_grant_d = 1'b0;
                end else if (w_m2_elig) begin
                    state_d      = C_GRANT2;
                    m2_grant_d   = 1'b1;
                    bus_owner_d  = C_OWN_M2;
                    last_grant_d = 1'b1;
                end
            end

            C_GRANT1, C_GRANT2: begin
                // A split outranks a simultaneous release of the request.
                if (w_split_rise) begin
                    state_d         = C_IDLE;
                    split_pending_d = 1'b1;
                    split_master_d  = (state_q == C_GRANT2);
                    if (state_q == C_GRANT2) begin
                        m2_split_d = 1'b1;
                    end else begin
                        m1_split_d = 1'b1;
                    end
                    m1_grant_d  = 1'b0;
                    m2_grant_d  = 1'b0;
                    bus_owner_d = C_OWN_NONE;
                end else if (!w_owner_breq) begin
                    state_d     = C_IDLE;
                    m1_grant_d  = 1'b0;
                    m2_grant_d  = 1'b0;
                    bus_owner_d = C_OWN_NONE;
                end
            end

            C_SPLIT_RET: begin
                if (!w_split_master_breq) begin
                    state_d         = C_IDLE;
                    split_grant_d   = 1'b0;
                    split_pending_d = 1'b0;
                    m1_grant_d      = 1'b0;
                    m2_grant_d      = 1'b0;
                    bus_owner_d     = C_OWN_NONE;
                end
            end

            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= C_IDLE;
            ssplit_dly_q    <= 1'b0;
            split_pending_q <= 1'b0;
            split_master_q  <= 1'b0;
            last_grant_q    <= 1'b1;
            m1_grant_q      <= 1'b0;
            m2_grant_q      <= 1'b0;
            m1_split_q      <= 1'b0;
            m2_split_q      <= 1'b0;
            split_grant_q   <= 1'b0;
            bus_owner_q     <= C_OWN_NONE;
        end else begin
            state_q         <= state_d;
            ssplit_dly_q    <= ssplit_dly_d;
            split_pending_q <= split_pending_d;
            split_master_q  <= split_master_d;
            last_grant_q    <= last_grant_d;
            m1_grant_q      <= m1_grant_d;
            m2_grant_q      <= m2_grant_d;
            m1_split_q      <= m1_split_d;
            m2_split_q      <= m2_split_d;
            split_grant_q   <= split_grant_d;
            bus_owner_q     <= bus_owner_d;
        end
    end

    assign m1_grant    = m1_grant_q;
    assign m2_grant    = m2_grant_q;
    assign m1_split    = m1_split_q;
    assign m2_split    = m2_split_q;
    assign split_grant = split_grant_q;
    assign bus_owner   = bus_owner_q;

endmodule
`default_nettype wire

// File: tb/tb_split_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_split_arbiter
// Brief    : Directed bench for split_arbiter, split enabled and disabled.
// Revision : 1.0
// ============================================================================
module tb_split_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       m1_breq;
    logic       m2_breq;
    logic       ssplit;
    logic [1:0] m1_grant;
    logic [1:0] m2_grant;
    logic [1:0] m1_split;
    logic [1:0] m2_split;
    logic [1:0] split_grant;
    logic [1:0] bo0;
    logic [1:0] bo1;

    int checks   = 0;
    int failures = 0;
    int cycn     = 0;

    // Abstract model per instance: current owner (0 none, 1, 2), whether the
    // tenure is a split return, parked master (0 none), and next RR winner.
    int own  [2];
    bit ret  [2];
    int park [2];
    bit sprev[2];
    int rr   [2];

    always #5 clk = ~clk;

    split_arbiter #(.SPLIT_EN(1'b1)) u_en (
        .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
        .m1_grant(m1_grant[0]), .m2_grant(m2_grant[0]),
        .m1_split(m1_split[0]), .m2_split(m2_split[0]),
        .ssplit(ssplit), .split_grant(split_grant[0]), .bus_owner(bo0)
    );

    split_arbiter #(.SPLIT_EN(1'b0)) u_dis (
        .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
        .m1_grant(m1_grant[1]), .m2_grant(m2_grant[1]),
        .m1_split(m1_split[1]), .m2_split(m2_split[1]),
        .ssplit(ssplit), .split_grant(split_grant[1]), .bus_owner(bo1)
    );

    task automatic model_step();
        bit req [3];
        bit rise;
        bit e1;
        bit e2;
        req[0] = 1'b0;
        req[1] = m1_breq;
        req[2] = m2_breq;
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                own[k] = 0; ret[k] = 1'b0; park[k] = 0; sprev[k] = 1'b0; rr[k] = 1;
            end else begin
                rise = (k == 0) && ssplit && !sprev[k];
                if (own[k] == 0) begin
                    if (park[k] != 0 && !ssplit) begin
                        own[k] = park[k];
                        ret[k] = 1'b1;
                        rr[k]  = 3 - park[k];
                    end else begin
                        e1 = req[1] && park[k] != 1;
                        e2 = req[2] && park[k] != 2;
                        if (e1 && e2)  own[k] = rr[k];
                        else if (e1)   own[k] = 1;
                        else if (e2)   own[k] = 2;
                        if (own[k] != 0) rr[k] = 3 - own[k];
                    end
                end else if (ret[k]) begin
                    if (!req[own[k]]) begin
                        own[k] = 0; ret[k] = 1'b0; park[k] = 0;
                    end
                end else if (rise && park[k] == 0) begin
                    park[k] = own[k];
                    own[k]  = 0;
                end else if (!req[own[k]]) begin
                    own[k] = 0;
                end
                sprev[k] = ssplit;
            end
        end
    endtask

    function automatic logic [6:0] expv(int k);
        logic [1:0] bo;
        bo = 2'(own[k]);
        return {own[k] == 1, own[k] == 2,
                park[k] == 1 && !ret[k], park[k] == 2 && !ret[k],
                ret[k], bo};
    endfunction

    task automatic compare();
        logic [6:0] act [2];
        logic [6:0] ex;
        act[0] = {m1_grant[0], m2_grant[0], m1_split[0], m2_split[0], split_grant[0], bo0};
        act[1] = {m1_grant[1], m2_grant[1], m1_split[1], m2_split[1], split_grant[1], bo1};
        for (int k = 0; k < 2; k++) begin
            ex = expv(k);
            checks++;
            if (act[k] !== ex) begin
                failures++;
                $display("FAIL model_cmp_dut%0d cyc=%0d actual=%b required=%b (g1 g2 s1 s2 sg owner)",
                         k, cycn, act[k], ex);
            end
        end
    endtask

    // One clock: model consumes the inputs sampled at the edge, outputs
    // are compared half a period later.
    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cycn++;
            compare();
        end
    endtask

    task automatic chk(string name, logic [1:0] act, logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cycn, act, req);
        end
    endtask

    initial begin
        rstn = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0; ssplit = 1'b0;
        @(negedge clk);
        cyc(2);
        chk("reset_owner", bo0, 2'b00);
        chk("reset_grants", {m1_grant[0], m2_grant[0]}, 2'b00);
        rstn = 1'b1;
        cyc();

        // Single request, five sampled-high edges
        m1_breq = 1'b1;
        cyc();
        chk("single_grant", {m1_grant[0], bo0[0]}, 2'b11);
        cyc(4);
        chk("single_hold", bo0, 2'b01);
        m1_breq = 1'b0;
        cyc();
        chk("single_release", bo0, 2'b00);
        cyc();

        // Contention from reset: m1, idle gap, m2, then m1 again
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        m1_breq = 1'b1; m2_breq = 1'b1;
        cyc();
        chk("contend_first_m1", {m1_grant[0], m2_grant[0]}, 2'b10);
        cyc();
        m1_breq = 1'b0;
        cyc();
        chk("contend_idle_gap", bo0, 2'b00);
        cyc();
        chk("contend_then_m2", bo0, 2'b10);
        m1_breq = 1'b1;
        cyc();
        chk("no_preempt", {m1_grant[0], m2_grant[0]}, 2'b01);
        m2_breq = 1'b0;
        cyc();
        m2_breq = 1'b1;
        cyc();
        chk("rr_back_to_m1", bo0, 2'b01);
        m1_breq = 1'b0; m2_breq = 1'b0;
        cyc(2);

        // Split of m1 while m2 waits, return after m2 releases
        m1_breq = 1'b1;
        cyc();
        ssplit = 1'b1; m2_breq = 1'b1;
        cyc();
        chk("split_m1_flag", {m1_split[0], m1_grant[0]}, 2'b10);
        cyc();
        chk("split_m2_granted", bo0, 2'b10);
        cyc(2);
        ssplit = 1'b0;
        cyc();
        chk("split_m2_holds", {m2_grant[0], split_grant[0]}, 2'b10);
        m2_breq = 1'b0;
        cyc();
        cyc();
        chk("split_ret_m1", {split_grant[0], m1_grant[0]}, 2'b11);
        chk("split_ret_owner", bo0, 2'b01);
        m1_breq = 1'b0;
        cyc();
        chk("split_ret_done", {split_grant[0], m1_grant[0]}, 2'b00);
        cyc();

        // Split coinciding with breq drop, then ready while idle
        m2_breq = 1'b1;
        cyc();
        ssplit = 1'b1; m2_breq = 1'b0;
        cyc();
        chk("split_beats_release", {m2_split[0], m2_grant[0]}, 2'b10);
        m2_breq = 1'b1;
        cyc();
        chk("parked_no_grant", bo0, 2'b00);
        ssplit = 1'b0;
        cyc();
        chk("ready_idle_ret", {split_grant[0], m2_grant[0]}, 2'b11);
        m2_breq = 1'b0;
        cyc(2);

        // Ready while m1 owns, second rise ignored
        m2_breq = 1'b1;
        cyc();
        ssplit = 1'b1;
        cyc();
        m1_breq = 1'b1;
        cyc();
        ssplit = 1'b0;
        cyc();
        chk("ready_wait_owner", {m1_grant[0], split_grant[0]}, 2'b10);
        ssplit = 1'b1;
        cyc();
        chk("second_split_ignored", {m1_grant[0], m1_split[0]}, 2'b10);
        ssplit = 1'b0; m1_breq = 1'b0;
        cyc();
        chk("owner_released", bo0, 2'b00);
        cyc();
        chk("ret_after_owner", {split_grant[0], m2_grant[0]}, 2'b11);
        m2_breq = 1'b0;
        cyc(2);

        // Split disabled instance ignores ssplit
        m2_breq = 1'b1;
        cyc();
        ssplit = 1'b1;
        cyc();
        chk("dis_no_split", {m2_split[1], m2_grant[1]}, 2'b01);
        ssplit = 1'b0;
        cyc();
        chk("dis_hold", bo1, 2'b10);
        m2_breq = 1'b0;
        cyc();
        chk("dis_release", bo1, 2'b00);
        cyc(2);

        // Reset while a split is outstanding
        m1_breq = 1'b1;
        cyc();
        ssplit = 1'b1;
        cyc();
        chk("pre_reset_split", {m1_split[0], m1_grant[0]}, 2'b10);
        rstn = 1'b0;
        cyc();
        chk("mid_split_reset", {m1_split[0], split_grant[0]}, 2'b00);
        chk("mid_split_reset_owner", bo0, 2'b00);
        rstn = 1'b1; m1_breq = 1'b0; ssplit = 1'b0; m2_breq = 1'b1;
        cyc();
        chk("post_reset_m2", {m2_grant[0], bo0[1]}, 2'b11);
        m2_breq = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
